// File: rtl/addsub_pkg.sv
// Shared encodings for the chunked add/subtract unit.
// Operation select and FSM state enums.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBC = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit ripple-carry adder slice.
// Also exposes the carry into its top bit for overflow detection.
module chunk_adder #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i])
                    | (c[i] & (a[i] ^ b[i]));
  end

  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle add/sub: one chunk_adder reused across
// WIDTH/CHUNK cycles, with ADC/SBC carry chaining.
module chunked_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             negative,
  output logic             zero,
  output logic             carryout
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  if ((WIDTH % CHUNK) != 0 || CHUNK < 2) begin : g_bad
    $error("WIDTH must be a multiple of CHUNK, CHUNK >= 2");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             ov_q, ov_d;
  logic             neg_q, neg_d;
  logic             zero_q, zero_d;
  logic             cf_q, cf_d;
  logic             cin;

  logic [CHUNK-1:0] sum;
  logic             cout;
  logic             c_msb;

  chunk_adder #(.CHUNK(CHUNK)) u_add (
    .a        (a_q[CHUNK-1:0]),
    .b        (b_q[CHUNK-1:0]),
    .cin      (c_q),
    .sum      (sum),
    .cout     (cout),
    .c_msb_in (c_msb)
  );

  always_comb begin
    cin = cf_q;
    unique case (op_e'(op))
      OP_ADD:  cin = 1'b0;
      OP_SUB:  cin = 1'b1;
      OP_ADC:  cin = cf_q;
      OP_SBC:  cin = cf_q;
      default: cin = cf_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    idx_d   = idx_q;
    res_d   = res_q;
    ov_d    = ov_q;
    neg_d   = neg_q;
    zero_d  = zero_q;
    cf_d    = cf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = A;
          b_d     = op[0] ? ~B : B;
          c_d     = cin;
          idx_d   = '0;
        end
      end
      S_RUN: begin
        // operands shift down so the adder always sees chunk 0
        a_d   = a_q >> CHUNK;
        b_d   = b_q >> CHUNK;
        c_d   = cout;
        idx_d = idx_q + 1'b1;
        res_d[int'(idx_q)*CHUNK +: CHUNK] = sum;
        if (idx_q == LAST) begin
          state_d = S_DONE;
          cf_d    = cout;
          ov_d    = c_msb ^ cout;
          neg_d   = res_d[WIDTH-1];
          zero_d  = ~|res_d;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      idx_q   <= '0;
      res_q   <= '0;
      ov_q    <= 1'b0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      cf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      ov_q    <= ov_d;
      neg_q   <= neg_d;
      zero_q  <= zero_d;
      cf_q    <= cf_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign result   = res_q;
  assign overflow = ov_q;
  assign negative = neg_q;
  assign zero     = zero_q;
  assign carryout = cf_q;

endmodule

// File: tb/tb_chunked_addsub.sv
// Scoreboard bench for chunked_addsub (WIDTH=64, CHUNK=16).
// Driver pushes expectations; monitor checks on done.
module tb_chunked_addsub;

  localparam int W = 64;
  localparam int C = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy, done;
  logic [W-1:0] result;
  logic         overflow, negative, zero, carryout;

  chunked_addsub #(.WIDTH(W), .CHUNK(C)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow),
    .negative (negative),
    .zero     (zero),
    .carryout (carryout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   fl;
    string        name;
  } exp_t;

  exp_t       sbq[$];
  int         n_vec = 0;
  int         n_bad = 0;
  logic [3:0] last_fl = 4'b0000;

  function automatic logic [W-1:0] flags();
    return {60'b0, overflow, negative, zero, carryout};
  endfunction

  task automatic chk(input string nm,
                     input logic [W-1:0] act,
                     input logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // monitor: every done must match the oldest expectation
  always @(negedge clk) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("spurious_done", {63'b0, done}, '0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk({e.name, "_res"}, result, e.res);
        chk({e.name, "_flags"}, flags(), {60'b0, e.fl});
      end
    end
  end

  task automatic run(input string        nm,
                     input logic [1:0]   o,
                     input logic [W-1:0] a,
                     input logic [W-1:0] b,
                     input logic [W-1:0] r,
                     input logic [3:0]   fl,
                     input bit           poke);
    int got;
    int nbusy;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    sbq.push_back('{r, fl, nm});
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = ~o;
    A     = ~a ^ 64'h5A5A_1234_C3C3_8765;
    B     = ~b;
    got   = 0;
    nbusy = 0;
    for (int k = 1; k <= 12 && got == 0; k++) begin
      @(negedge clk);
      if (k == 1)
        chk({nm, "_hold"}, flags(), {60'b0, last_fl});
      if (poke && k == 2) begin
        start = 1'b1;
        op    = 2'b00;
        A     = 64'h0123_4567_89AB_CDEF;
        B     = 64'h1111_1111_1111_1111;
      end
      if (poke && k == 3) start = 1'b0;
      if (busy === 1'b1) nbusy++;
      if (done === 1'b1) got = k;
    end
    chk({nm, "_done_cyc"}, W'(got), W'(5));
    chk({nm, "_busy_cyc"}, W'(nbusy), W'(4));
    if (poke) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    last_fl = fl;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_res", result, '0);
    chk("rst_ctl", {58'b0, busy, done, overflow,
                    negative, zero, carryout}, '0);
    @(negedge clk);
    reset_n = 1'b1;

    run("add_wrap", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF,
        64'd1, 64'd0, 4'b0011, 1'b0);
    run("adc_c1", 2'b10, 64'd0, 64'd0,
        64'd1, 4'b0000, 1'b0);
    run("add_chunk", 2'b00, 64'h0000_0000_0000_FFFF,
        64'd1, 64'h0000_0000_0001_0000, 4'b0000, 1'b0);
    run("sub_ovf", 2'b01, 64'h8000_0000_0000_0000,
        64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b1001, 1'b0);
    run("sub_neg", 2'b01, 64'd2, 64'd5,
        64'hFFFF_FFFF_FFFF_FFFD, 4'b0100, 1'b0);
    run("sbc_c0", 2'b11, 64'd10, 64'd3,
        64'd6, 4'b0001, 1'b0);
    run("sbc_c1", 2'b11, 64'd10, 64'd3,
        64'd7, 4'b0001, 1'b0);
    run("add_ovf", 2'b00, 64'h7FFF_FFFF_FFFF_FFFF,
        64'd1, 64'h8000_0000_0000_0000, 4'b1100, 1'b0);
    run("adc_c0", 2'b10, 64'd0, 64'd0,
        64'd0, 4'b0010, 1'b0);
    run("add_poke", 2'b00, 64'd1, 64'd1,
        64'd2, 4'b0000, 1'b1);

    // abort a run with reset in its third RUN cycle
    @(negedge clk);
    start = 1'b1;
    op    = 2'b00;
    A     = 64'd5;
    B     = 64'd6;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_res", result, '0);
    chk("abort_ctl", {58'b0, busy, done, overflow,
                      negative, zero, carryout}, '0);
    @(negedge clk);
    reset_n = 1'b1;
    last_fl = 4'b0000;

    run("add_after_rst", 2'b00, 64'd3, 64'd4,
        64'd7, 4'b0000, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", W'(sbq.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
